// File: rtl/aes_decrypter.sv
// Iterative AES-128 inverse cipher. It expands the key once into an 11-entry round-key store,
// then runs one inverse round per clock, with valid/ready handshakes on input and output.
module aes_decrypter (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_valid,
    input  logic [127:0] key,
    output logic         key_ready,
    input  logic         valid_in,
    input  logic [127:0] data_in,
    output logic         ready_in,
    output logic [127:0] data_out,
    output logic         valid_out,
    input  logic         ready_out,
    output logic         key_loaded
);
    // state  | meaning
    // IDLE   | no schedule held; only a key load is possible
    // KEYEXP | writing rk[1..10], one round key per cycle
    // READY  | schedule valid; accepts a key or a ciphertext block
    // ROUND  | inverse rounds 9 down to 1
    // FINAL  | last inverse round (no InvMixColumns, rk[0])
    // DONE   | plaintext presented until ready_out
    typedef enum logic [2:0] {IDLE, KEYEXP, READY, ROUND, FINAL, DONE} fsm_t;

    fsm_t         fsm, fsm_next;
    logic [127:0] rk [11];
    logic [127:0] st;
    logic [3:0]   kcnt, rnd;
    logic         key_load, blk_load;
    logic [127:0] prev_rk, next_rk, rows_sub, round_out, final_out;
    logic [31:0]  temp_w, w0, w1, w2, w3;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8), and it maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r, sq;
        r = 8'h01;
        sq = x;
        for (int i = 0; i < 7; i++) begin
            sq = gf_mul(sq, sq);
            r = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] g;
        g = gf_inv(x);
        return g ^ {g[6:0], g[7]} ^ {g[5:0], g[7:6]} ^ {g[4:0], g[7:5]} ^ {g[3:0], g[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return gf_inv({x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05);
    endfunction

    function automatic logic [127:0] inv_rows_sub(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = inv_sbox(s[127-8*(4*((c+4-r)%4)+r) -: 8]);
        return o;
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 32] = {
                gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
        end
        return o;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    always_comb begin
        prev_rk = rk[kcnt - 4'd1];
        temp_w  = {sbox(prev_rk[23:16]), sbox(prev_rk[15:8]), sbox(prev_rk[7:0]),
                   sbox(prev_rk[31:24])} ^ {rcon(kcnt), 24'h000000};
        w0      = prev_rk[127:96] ^ temp_w;
        w1      = prev_rk[95:64] ^ w0;
        w2      = prev_rk[63:32] ^ w1;
        w3      = prev_rk[31:0] ^ w2;
        next_rk = {w0, w1, w2, w3};
    end

    assign rows_sub  = inv_rows_sub(st);
    assign round_out = inv_mix(rows_sub ^ rk[rnd]);
    assign final_out = rows_sub ^ rk[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fsm <= IDLE;
        else        fsm <= fsm_next;
    end

    // A key request in READY masks ready_in so the key load always wins.
    always_comb begin
        fsm_next  = fsm;
        key_ready = 1'b0;
        ready_in  = 1'b0;
        valid_out = 1'b0;
        case (fsm)
            IDLE: begin
                key_ready = 1'b1;
                if (key_valid) fsm_next = KEYEXP;
            end
            KEYEXP: if (kcnt == 4'd10) fsm_next = READY;
            READY: begin
                key_ready = 1'b1;
                ready_in  = !key_valid;
                if (key_valid)     fsm_next = KEYEXP;
                else if (valid_in) fsm_next = ROUND;
            end
            ROUND: if (rnd == 4'd1) fsm_next = FINAL;
            FINAL: fsm_next = DONE;
            DONE: begin
                valid_out = 1'b1;
                if (ready_out) fsm_next = READY;
            end
            default: fsm_next = IDLE;
        endcase
    end

    assign key_load = key_valid & key_ready;
    assign blk_load = valid_in & ready_in;
    assign data_out = valid_out ? st : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st         <= '0;
            kcnt       <= '0;
            rnd        <= '0;
            key_loaded <= 1'b0;
            for (int i = 0; i < 11; i++) rk[i] <= '0;
        end else begin
            if (key_load) begin
                rk[0]      <= key;
                kcnt       <= 4'd1;
                key_loaded <= 1'b0;
            end else if (fsm == KEYEXP) begin
                rk[kcnt] <= next_rk;
                kcnt     <= kcnt + 4'd1;
                if (kcnt == 4'd10) key_loaded <= 1'b1;
            end
            if (blk_load) begin
                st  <= data_in ^ rk[10];
                rnd <= 4'd9;
            end else if (fsm == ROUND) begin
                st  <= round_out;
                rnd <= rnd - 4'd1;
            end else if (fsm == FINAL) begin
                st <= final_out;
            end
        end
    end
endmodule

// File: tb/tb_aes_decrypter.sv
// Directed and random bench for aes_decrypter. Random ciphertexts come from a
// behavioural AES-128 forward cipher, so each decrypted block must equal its plaintext.
module tb_aes_decrypter;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         key_valid = 1'b0;
    logic [127:0] key = '0;
    logic         key_ready;
    logic         valid_in = 1'b0;
    logic [127:0] data_in = '0;
    logic         ready_in;
    logic [127:0] data_out;
    logic         valid_out;
    logic         ready_out = 1'b1;
    logic         key_loaded;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    logic [7:0]   sb [256];
    logic [127:0] m_rk [11];

    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] RK10_B = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    aes_decrypter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_valid (key_valid),
        .key       (key),
        .key_ready (key_ready),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .ready_in  (ready_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .ready_out (ready_out),
        .key_loaded(key_loaded)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // S-box table walked along powers of the generator 3 and its inverse.
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        repeat (255) begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sb[p] = x ^ 8'h63;
        end
        sb[0] = 8'h63;
    endtask

    task automatic expand_key(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h000000};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) m_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] encrypt(input logic [127:0] pt);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] v;
        v = pt ^ m_rk[0];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sb[v[127-8*i -: 8]];
            for (int i = 0; i < 16; i++) t[i] = s[4*(((i/4)+(i%4))%4) + (i%4)];
            for (int i = 0; i < 16; i++) s[i] = t[i];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end
            for (int i = 0; i < 16; i++) v[127-8*i -: 8] = s[i];
            v = v ^ m_rk[r];
        end
        return v;
    endfunction

    task automatic load_key(input logic [127:0] k);
        int n;
        n = 0;
        while (!key_ready && n < 100) begin tick(); n++; end
        key = k;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        n = 0;
        while (!key_ready && n < 50) begin tick(); n++; end
        check("key_ready_low_cycles", 128'(n), 128'd10);
        check("key_loaded_after_exp", 128'(key_loaded), 128'd1);
    endtask

    // Latency = edges after the accept edge until valid_out is seen (accept is edge 1 of 11).
    task automatic send_block(input logic [127:0] d, output logic [127:0] res,
                              output int lat, output int acc_cyc);
        int n;
        n = 0;
        while (!ready_in && n < 100) begin tick(); n++; end
        data_in = d;
        valid_in = 1'b1;
        tick();
        acc_cyc = cyc;
        valid_in = 1'b0;
        lat = 0;
        while (!valid_out && lat < 60) begin tick(); lat++; end
        res = data_out;
    endtask

    initial begin
        logic [127:0] res, hold, kr, pt, ct;
        int lat, a0, a1, n;
        logic ok;

        build_sbox();

        tick();
        tick();
        check("rst_key_ready", 128'(key_ready), 128'd1);
        check("rst_ready_in", 128'(ready_in), 128'd0);
        check("rst_valid_out", 128'(valid_out), 128'd0);
        check("rst_data_out", data_out, 128'd0);
        check("rst_key_loaded", 128'(key_loaded), 128'd0);
        rst_n = 1'b1;
        tick();

        ok = 1'b1;
        data_in = CT_C1;
        valid_in = 1'b1;
        repeat (20) begin
            tick();
            if (ready_in !== 1'b0 || valid_out !== 1'b0) ok = 1'b0;
        end
        valid_in = 1'b0;
        check("no_accept_without_key", 128'(ok), 128'd1);

        load_key(KEY_C1);
        check("ready_in_after_keyexp", 128'(ready_in), 128'd1);
        send_block(CT_C1, res, lat, a0);
        check("c1_plaintext", res, PT_C1);
        check("c1_latency", 128'(lat), 128'd10);

        // Key request mid-block must be ignored and the old key kept.
        n = 0;
        while (!ready_in && n < 100) begin tick(); n++; end
        data_in = CT_C1;
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        tick();
        tick();
        key = KEY_B;
        key_valid = 1'b1;
        #1;
        check("key_ready_in_round", 128'(key_ready), 128'd0);
        tick();
        key_valid = 1'b0;
        lat = 0;
        while (!valid_out && lat < 60) begin tick(); lat++; end
        check("round_rekey_ignored", data_out, PT_C1);

        ready_out = 1'b0;
        send_block(CT_C1, res, lat, a0);
        check("bp_plaintext", res, PT_C1);
        hold = data_out;
        ok = 1'b1;
        data_in = CT_B;
        valid_in = 1'b1;
        repeat (20) begin
            tick();
            if (data_out !== hold || valid_out !== 1'b1 || ready_in !== 1'b0) ok = 1'b0;
        end
        check("bp_hold_20", 128'(ok), 128'd1);
        valid_in = 1'b0;
        ready_out = 1'b1;
        tick();
        check("bp_release_valid_out", 128'(valid_out), 128'd0);
        check("bp_release_ready_in", 128'(ready_in), 128'd1);

        send_block(CT_C1, res, lat, a0);
        send_block(CT_C1, res, lat, a1);
        check("b2b_plaintext", res, PT_C1);
        check("b2b_spacing", 128'(a1 - a0), 128'd12);

        tick();
        key = KEY_B;
        key_valid = 1'b1;
        data_in = CT_C1;
        valid_in = 1'b1;
        #1;
        check("prio_ready_in", 128'(ready_in), 128'd0);
        tick();
        key_valid = 1'b0;
        valid_in = 1'b0;
        check("prio_key_loaded_drop", 128'(key_loaded), 128'd0);
        n = 0;
        ok = 1'b1;
        while (!key_ready && n < 50) begin
            tick();
            n++;
            if (valid_out !== 1'b0) ok = 1'b0;
        end
        check("prio_keyexp_cycles", 128'(n), 128'd10);
        check("prio_no_output", 128'(ok), 128'd1);
        expand_key(KEY_B);
        check("model_rk10_b", m_rk[10], RK10_B);
        send_block(CT_B, res, lat, a0);
        check("b_plaintext", res, PT_B);

        kr = {$urandom(), $urandom(), $urandom(), $urandom()};
        load_key(kr);
        expand_key(kr);
        for (int i = 0; i < 8; i++) begin
            pt = {$urandom(), $urandom(), $urandom(), $urandom()};
            ct = encrypt(pt);
            send_block(ct, res, lat, a0);
            check($sformatf("rand_%0d", i), res, pt);
        end

        send_block(CT_B, res, lat, a0);
        tick();
        n = 0;
        while (!ready_in && n < 100) begin tick(); n++; end
        data_in = CT_B;
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        check("midrst_valid_out", 128'(valid_out), 128'd0);
        check("midrst_key_loaded", 128'(key_loaded), 128'd0);
        check("midrst_ready_in", 128'(ready_in), 128'd0);
        tick();
        rst_n = 1'b1;
        ok = 1'b1;
        data_in = CT_C1;
        valid_in = 1'b1;
        repeat (20) begin
            tick();
            if (valid_out !== 1'b0 || key_loaded !== 1'b0 || ready_in !== 1'b0) ok = 1'b0;
        end
        valid_in = 1'b0;
        check("midrst_quiet", 128'(ok), 128'd1);
        load_key(KEY_C1);
        send_block(CT_C1, res, lat, a0);
        check("midrst_reload_plaintext", res, PT_C1);
        check("midrst_reload_latency", 128'(lat), 128'd10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
